// File: rtl/maze_renderer_if.sv
// maze_renderer_if: pixel, tile-write and player-position signals of maze_renderer
interface maze_renderer_if;
    logic [9:0]  i;
    logic [9:0]  j;
    logic        printing;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [1:0]  wr_data;
    logic        pos_valid;
    logic [5:0]  pos_x;
    logic [4:0]  pos_y;
    logic        pos_ready;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        frame_done;

    modport master (
        output i, j, printing, wr_en, wr_addr, wr_data, pos_valid, pos_x, pos_y,
        input  pos_ready, pix_r, pix_g, pix_b, frame_done
    );

    modport slave (
        input  i, j, printing, wr_en, wr_addr, wr_data, pos_valid, pos_x, pos_y,
        output pos_ready, pix_r, pix_g, pix_b, frame_done
    );
endinterface

// File: rtl/maze_renderer.sv
// maze_renderer: 40x30 tile-map renderer with a frame-synchronised player sprite; MAZE_GRID_EN adds a grey tile grid
module maze_renderer #(
    parameter logic [23:0] COLOR_FLOOR  = 24'h000000,
    parameter logic [23:0] COLOR_WALL   = 24'h0000FF,
    parameter logic [23:0] COLOR_CHEESE = 24'hFFFF00,
    parameter logic [23:0] COLOR_EXIT   = 24'h00FF00,
    parameter logic [23:0] COLOR_PLAYER = 24'hFF0000
) (
    input logic            CLOCK_50,
    input logic            reset,
    maze_renderer_if.slave bus
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t      r_state;
    logic [1:0]  r_mem [0:1199];
    logic [1:0]  r_tile;
    logic        r_v1;
    logic        r_hit;
    logic        r_last;
    logic        r_ready;
    logic [5:0]  r_app_x;
    logic [4:0]  r_app_y;
    logic [5:0]  r_pend_x;
    logic [4:0]  r_pend_y;
    logic [23:0] r_color;
    logic [11:0] w_idx;
    logic        w_hit;
    logic        w_frame_done;
    logic [23:0] w_tile_color;
    logic [23:0] w_base_color;

    // 12 bits so out-of-screen rows cannot wrap back into the valid index range
    assign w_idx = 12'(bus.i[9:4]) * 12'd40 + 12'(bus.j[9:4]);
    assign w_hit = bus.j[9:4] == r_app_x && bus.i[9:4] == {1'b0, r_app_y} &&
                   bus.i[3:0] >= 4'd2 && bus.i[3:0] <= 4'd13 &&
                   bus.j[3:0] >= 4'd2 && bus.j[3:0] <= 4'd13;
    assign w_frame_done = r_last && !bus.printing;
    assign w_tile_color = r_tile == 2'd0 ? COLOR_FLOOR :
                          r_tile == 2'd1 ? COLOR_WALL  :
                          r_tile == 2'd2 ? COLOR_CHEESE : COLOR_EXIT;

`ifdef MAZE_GRID_EN
    logic [3:0] r_i_lo;
    logic [3:0] r_j_lo;

    // pixel-in-tile offsets travel with the pixel to place the grid lines
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_i_lo <= '0;
            r_j_lo <= '0;
        end else begin
            r_i_lo <= bus.i[3:0];
            r_j_lo <= bus.j[3:0];
        end
    end

    assign w_base_color = (r_i_lo == 4'd0 || r_j_lo == 4'd0) ? 24'h404040 : w_tile_color;
`else
    assign w_base_color = w_tile_color;
`endif

    // tile RAM: not reset, read returns the pre-write value on a same-address collision
    always_ff @(posedge CLOCK_50) begin
        if (bus.wr_en && bus.wr_addr < 11'd1200) r_mem[bus.wr_addr] <= bus.wr_data;
        r_tile <= (w_idx < 12'd1200) ? r_mem[w_idx[10:0]] : 2'd0;
    end

    // stage 1: pixel valid, sprite hit and end-of-frame detection
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_v1   <= 1'b0;
            r_hit  <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_v1   <= bus.printing;
            r_hit  <= w_hit;
            r_last <= bus.printing && bus.i == 10'd479 && bus.j == 10'd639;
        end
    end

    // stage 2: final pixel colour, sprite over grid over tile
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) r_color <= '0;
        else r_color <= !r_v1 ? 24'h000000 : r_hit ? COLOR_PLAYER : w_base_color;
    end

    // position handshake: hold one clamped offer until the frame ends, then apply it
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_app_x  <= '0;
            r_app_y  <= '0;
            r_pend_x <= '0;
            r_pend_y <= '0;
        end else if (r_state == IDLE) begin
            if (bus.pos_valid) begin
                r_pend_x <= bus.pos_x > 6'd39 ? 6'd39 : bus.pos_x;
                r_pend_y <= bus.pos_y > 5'd29 ? 5'd29 : bus.pos_y;
                r_state  <= PENDING;
                r_ready  <= 1'b0;
            end
        end else if (w_frame_done) begin
            r_app_x <= r_pend_x;
            r_app_y <= r_pend_y;
            r_state <= IDLE;
            r_ready <= 1'b1;
        end
    end

    assign bus.pos_ready  = r_ready;
    assign bus.frame_done = w_frame_done;
    assign bus.pix_r      = r_color[23:16];
    assign bus.pix_g      = r_color[15:8];
    assign bus.pix_b      = r_color[7:0];
endmodule

// File: tb/tb_maze_renderer.sv
// tb_maze_renderer: random and directed stimulus against a behavioural screen/handshake model
module tb_maze_renderer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [1:0]  m_map [1200];
    int          app_x, app_y, pend_x, pend_y;
    bit          m_pend, m_last;
    logic [23:0] e1, e2;

    maze_renderer_if bus ();

    maze_renderer dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(int ii, int jj, bit pr);
        int ti, tj;
        if (!pr) return 24'h000000;
        ti = ii % 16;
        tj = jj % 16;
        if (jj / 16 == app_x && ii / 16 == app_y && ti >= 2 && ti <= 13 && tj >= 2 && tj <= 13)
            return 24'hFF0000;
`ifdef MAZE_GRID_EN
        if (ti == 0 || tj == 0) return 24'h404040;
`endif
        case (m_map[(ii / 16) * 40 + jj / 16])
            2'd0:    return 24'h000000;
            2'd1:    return 24'h0000FF;
            2'd2:    return 24'hFFFF00;
            default: return 24'h00FF00;
        endcase
    endfunction

    function automatic logic [23:0] pix();
        return {bus.pix_r, bus.pix_g, bus.pix_b};
    endfunction

    // called just after a falling edge with this cycle's inputs already driven
    task automatic tick();
        bit fd;
        #1;
        fd = m_last && !bus.printing;
        check("pix", pix(), e2);
        check("frame_done", {23'd0, bus.frame_done}, {23'd0, fd});
        check("pos_ready", {23'd0, bus.pos_ready}, {23'd0, !m_pend});
        e2 = e1;
        e1 = model_pix(int'(bus.i), int'(bus.j), bus.printing);
        if (bus.wr_en && bus.wr_addr < 1200) m_map[bus.wr_addr] = bus.wr_data;
        if (!m_pend) begin
            if (bus.pos_valid) begin
                pend_x = bus.pos_x > 39 ? 39 : int'(bus.pos_x);
                pend_y = bus.pos_y > 29 ? 29 : int'(bus.pos_y);
                m_pend = 1;
            end
        end else if (fd) begin
            app_x  = pend_x;
            app_y  = pend_y;
            m_pend = 0;
        end
        m_last = bus.printing && bus.i == 479 && bus.j == 639;
        @(negedge clk);
    endtask

    task automatic drive(input int we, input int wa, input int wd, input int pv, input int px,
                         input int py, input int pr, input int ii, input int jj);
        bus.wr_en     = we[0];
        bus.wr_addr   = wa[10:0];
        bus.wr_data   = wd[1:0];
        bus.pos_valid = pv[0];
        bus.pos_x     = px[5:0];
        bus.pos_y     = py[4:0];
        bus.printing  = pr[0];
        bus.i         = ii[9:0];
        bus.j         = jj[9:0];
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.pos_valid = 1'b0;
        bus.printing  = 1'b0;
        #2;
        check("rst_pix", pix(), 24'h000000);
        check("rst_frame_done", {23'd0, bus.frame_done}, 24'd0);
        check("rst_pos_ready", {23'd0, bus.pos_ready}, 24'd1);
        @(negedge clk);
        check("rst_hold_pix", pix(), 24'h000000);
        rst_n  = 1'b1;
        m_pend = 0;
        m_last = 0;
        app_x  = 0;
        app_y  = 0;
        pend_x = 0;
        pend_y = 0;
        e1     = '0;
        e2     = '0;
    endtask

    task automatic frame_end();
        drive(0, 0, 0, 0, 0, 0, 1, 479, 639);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.i = '0; bus.j = '0; bus.printing = 0; bus.wr_en = 0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.pos_valid = 0; bus.pos_x = '0; bus.pos_y = '0;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 1200; k++) drive(1, k, int'($urandom_range(3)), 0, 0, 0, 0, 0, 0);
        idle();
        // wall tile at row 1, col 1
        drive(1, 41, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 16, 16);
        idle();
        #1;
`ifdef MAZE_GRID_EN
        check("wall_16_16", pix(), 24'h404040);
`else
        check("wall_16_16", pix(), 24'h0000FF);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 300, 300);
        idle();
        idle();
        // out-of-range offer clamps; second offer while pending is dropped
        drive(0, 0, 0, 1, 45, 31, 0, 0, 0);
        drive(0, 0, 0, 1, 5, 5, 0, 0, 0);
        idle();
        frame_end();
        drive(0, 0, 0, 0, 0, 0, 1, 466, 626);
        idle();
        #1;
        check("player_39_29", pix(), 24'hFF0000);
        idle();
        // out-of-range write, then same-cycle read/write of tile 0
        drive(1, 1200, 3, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 2, 0, 0, 0, 1, 5, 5);
        drive(0, 0, 0, 0, 0, 0, 1, 5, 5);
        #1;
        check("collide_old", pix(), 24'h000000);
        idle();
        #1;
        check("collide_new", pix(), 24'hFFFF00);
        // reset while pending drops the offer and re-centres the sprite at (0,0)
        drive(1, 0, 0, 1, 20, 10, 0, 0, 0);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 5, 5);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 5);
        idle();
        idle();
        frame_end();
        drive(0, 0, 0, 0, 0, 0, 1, 165, 325);
        idle();
        idle();
        for (int k = 0; k < 4000; k++) begin
            int ii, jj, pr;
            pr = ($urandom_range(3) != 0) ? 1 : 0;
            ii = int'($urandom_range(479));
            jj = int'($urandom_range(639));
            if ($urandom_range(3) == 0) begin
                ii = app_y * 16 + int'($urandom_range(15));
                jj = app_x * 16 + int'($urandom_range(15));
            end
            if (k % 97 == 0) begin
                pr = 1;
                ii = 479;
                jj = 639;
            end else if (k % 97 == 1) pr = 0;
            drive(int'($urandom_range(1)), int'($urandom_range(1299)), int'($urandom_range(3)),
                  ($urandom_range(7) == 0) ? 1 : 0, int'($urandom_range(63)), int'($urandom_range(31)),
                  pr, ii, jj);
        end
        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
